voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
Downstream neighbour of the ADSR stage. Consumes the time-multiplexed, envelope-scaled per-voice samples (ADSR o_sample / o_voice_index_next) and sums all voices of one frame into a wide accumulator. At frame end it scales and saturates the sum to 16 bits and presents it on a valid/ready output to the DAC/I2S serializer. It also detects out-of-sequence voice indices, saturation and output overruns.

Parameters:
VOICE_BITS, 8, width of the voice index
NUM_VOICES, 256, voices per frame; last index is NUM_VOICES-1, must be ≤ 2^VOICE_BITS
ACC_WIDTH, 24, accumulator width; must be ≥ 16+VOICE_BITS

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_pipeline_state  in  2  shared voice pipeline phase (same bus the ADSR sees)
i_voice_index  in  VOICE_BITS  voice index of i_sample (from ADSR o_voice_index_next)
i_sample  in  16 signed  enveloped voice sample (from ADSR o_sample)
i_gain_shift  in  4  arithmetic right shift applied to the frame sum, 0..15
i_sample_ready  in  1  output consumer accepts o_sample
o_sample  out  16 signed  mixed, scaled, saturated frame sample
o_sample_valid  out  1  o_sample holds an unconsumed frame
o_clipped  out  1  saturation occurred for the frame in o_sample
o_frame_error  out  1  one-cycle pulse: voice index out of sequence
o_overrun  out  1  one-cycle pulse: unconsumed frame overwritten

Behaviour:
- Reset (async assert, sync release): all outputs 0, accumulator 0, expected index 0, FSM in SYNC.
- Capture event: first clock with i_pipeline_state==2 after a clock where it was ≠2 (edge detect on registered previous phase). One capture per voice. i_sample and i_voice_index are sampled on that edge. prev-phase register resets to 0.
- FSM states SYNC, ACCUM:
  - SYNC: captures with index≠0 ignored, no error. Index 0 → acc = sext(i_sample), expected = 1, go ACCUM.
  - ACCUM, index==expected: acc = acc + sext(i_sample); expected++. If index==NUM_VOICES-1 → frame complete, go SYNC, expected = 0.
  - ACCUM, index==0 (premature restart): o_frame_error pulse, partial frame discarded, acc = sext(i_sample), expected = 1, stay ACCUM.
  - ACCUM, any other mismatch: o_frame_error pulse, acc discarded, go SYNC.
  - NUM_VOICES==1: index 0 in SYNC completes the frame immediately.
- Frame completion (registered on the same edge as the final capture, i.e. output visible one cycle after final sample is presented):
  - sum = acc + sext(final sample), ACC_WIDTH bits, no internal overflow by width rule.
  - shifted = sum >>> i_gain_shift (arithmetic, truncation toward -inf).
  - shifted > 32767 → o_sample = 32767, o_clipped = 1; shifted < -32768 → -32768, o_clipped = 1; else o_sample = shifted[15:0], o_clipped = 0.
  - o_sample_valid = 1.
- Output handshake:
  - Transfer when o_sample_valid && i_sample_ready on a clock edge; valid clears next cycle.
  - o_sample/o_clipped held stable while valid=1 and not transferred.
  - Completion while valid=1 and i_sample_ready=0: new frame overwrites, valid stays 1, o_overrun pulses one cycle.
  - Completion in same cycle as a transfer: new frame loaded, valid stays 1, no overrun.
- i_gain_shift sampled only at completion; changes mid-frame are legal.
- Reset mid-frame: partial sum and pending output lost; resumes in SYNC.

Test Plan:
- NUM_VOICES=4, i_gain_shift=0, ready=1, samples 100,200,-50,25 at indices 0..3 → one valid pulse, o_sample=275, o_clipped=0.
- NUM_VOICES=4, shift=0, four samples of 20000 → o_sample=32767, o_clipped=1; four of -20000 → -32768, o_clipped=1; shift=2 with same +20000 → 20000, o_clipped=0.
- Indices 0,1,3 → o_frame_error pulse at index-3 capture, no output; next 0..3 of 1 each → o_sample=4. Indices 0,1,0,1,2,3 of 10 each → error at second 0, output 40.
- Start mid-stream at index 2 after reset → indices 2,3 ignored without error; first output only after full 0..3 sequence.
- ready=0 across two complete frames (sums 10 then 20) → o_sample stays 10 until second completion, then 20 with one-cycle o_overrun; ready=1 in completion cycle → no overrun.
- Assert i_reset_n low asynchronously mid-frame with valid=1 → all outputs 0 immediately; after release, frame 0..3 produces correct sum.

Source files
------------

// File: rtl/voice_mixer_if.sv
// Port bundle between the voice pipeline and the frame mixer.
// master = sample producer / output consumer side, slave = the mixer itself.
interface voice_mixer_if #(
  parameter int VOICE_BITS = 8
);
  logic [1:0]            i_pipeline_state;
  logic [VOICE_BITS-1:0] i_voice_index;
  logic signed [15:0]    i_sample;
  logic [3:0]            i_gain_shift;
  logic                  i_sample_ready;
  logic signed [15:0]    o_sample;
  logic                  o_sample_valid;
  logic                  o_clipped;
  logic                  o_frame_error;
  logic                  o_overrun;
  logic                  o_dbg_accum;

  // Output handshake: a frame transfers on any rising edge where
  // o_sample_valid && i_sample_ready; o_sample/o_clipped stay stable while
  // valid is high and not yet transferred, and valid never drops without one.
  modport master (
    output i_pipeline_state, i_voice_index, i_sample, i_gain_shift, i_sample_ready,
    input  o_sample, o_sample_valid, o_clipped, o_frame_error, o_overrun, o_dbg_accum
  );

  modport slave (
    input  i_pipeline_state, i_voice_index, i_sample, i_gain_shift, i_sample_ready,
    output o_sample, o_sample_valid, o_clipped, o_frame_error, o_overrun, o_dbg_accum
  );
endinterface

// File: rtl/voice_mixer.sv
// Sums one frame of time-multiplexed voice samples, scales and saturates the
// total to 16 bits and offers it on a valid/ready output.
module voice_mixer #(
  parameter int VOICE_BITS = 8,
  parameter int NUM_VOICES = 256,
  parameter int ACC_WIDTH  = 24
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  voice_mixer_if.slave  bus
);

  typedef enum logic {ST_SYNC, ST_ACCUM} state_t;

  localparam logic [VOICE_BITS-1:0]        LAST_IDX = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0]        ONE_IDX  = VOICE_BITS'(1);
  localparam logic signed [ACC_WIDTH-1:0]  POS_LIM  = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0]  NEG_LIM  = ACC_WIDTH'(-32768);

  state_t                       state;
  logic [1:0]                   prev_phase;
  logic [VOICE_BITS-1:0]        expected;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                         capture;
  logic                         idx_zero;
  logic                         idx_match;
  logic                         complete;
  logic signed [ACC_WIDTH-1:0]  sample_ext;
  logic signed [ACC_WIDTH-1:0]  frame_sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [15:0]           sat_sample;
  logic                         sat_clip;

  assign capture    = (bus.i_pipeline_state == 2'd2) && (prev_phase != 2'd2);
  assign idx_zero   = (bus.i_voice_index == '0);
  assign idx_match  = (bus.i_voice_index == expected);
  assign sample_ext = {{(ACC_WIDTH-16){bus.i_sample[15]}}, bus.i_sample};

  // In SYNC the accumulator content is stale, so a frame starts from zero.
  assign frame_sum  = ((state == ST_ACCUM) ? acc : {ACC_WIDTH{1'b0}}) + sample_ext;
  assign shifted    = frame_sum >>> bus.i_gain_shift;

  assign complete = capture &&
                    (((state == ST_SYNC) && idx_zero && (NUM_VOICES == 1)) ||
                     ((state == ST_ACCUM) && idx_match && (bus.i_voice_index == LAST_IDX)));

  always_comb begin
    sat_sample = shifted[15:0];
    sat_clip   = 1'b0;
    if (shifted > POS_LIM) begin
      sat_sample = 16'sh7fff;
      sat_clip   = 1'b1;
    end else if (shifted < NEG_LIM) begin
      sat_sample = -16'sh8000;
      sat_clip   = 1'b1;
    end
  end

  assign bus.o_dbg_accum = (state == ST_ACCUM);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state              <= ST_SYNC;
      prev_phase         <= 2'd0;
      expected           <= '0;
      acc                <= '0;
      bus.o_sample       <= '0;
      bus.o_sample_valid <= 1'b0;
      bus.o_clipped      <= 1'b0;
      bus.o_frame_error  <= 1'b0;
      bus.o_overrun      <= 1'b0;
    end else begin
      prev_phase        <= bus.i_pipeline_state;
      bus.o_frame_error <= 1'b0;
      bus.o_overrun     <= 1'b0;

      if (bus.o_sample_valid && bus.i_sample_ready) begin
        bus.o_sample_valid <= 1'b0;
      end

      // A completion always wins over a same-edge transfer; overrun only when
      // the pending frame was not taken on this edge.
      if (complete) begin
        bus.o_sample       <= sat_sample;
        bus.o_clipped      <= sat_clip;
        bus.o_sample_valid <= 1'b1;
        if (bus.o_sample_valid && !bus.i_sample_ready) begin
          bus.o_overrun <= 1'b1;
        end
      end

      if (capture) begin
        case (state)
          ST_SYNC: begin
            if (idx_zero) begin
              acc <= sample_ext;
              if (NUM_VOICES == 1) begin
                expected <= '0;
              end else begin
                expected <= ONE_IDX;
                state    <= ST_ACCUM;
              end
            end
          end
          ST_ACCUM: begin
            if (idx_match) begin
              if (bus.i_voice_index == LAST_IDX) begin
                state    <= ST_SYNC;
                expected <= '0;
                acc      <= '0;
              end else begin
                acc      <= frame_sum;
                expected <= expected + ONE_IDX;
              end
            end else if (idx_zero) begin
              bus.o_frame_error <= 1'b1;
              acc               <= sample_ext;
              expected          <= ONE_IDX;
            end else begin
              bus.o_frame_error <= 1'b1;
              acc               <= '0;
              expected          <= '0;
              state             <= ST_SYNC;
            end
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed frames plus randomized streams checked
// against a frame-level reference model.
module tb_voice_mixer;

  localparam int NV = 4;

  logic clk;
  logic rst_n;

  voice_mixer_if #(.VOICE_BITS(8)) bus ();

  voice_mixer #(
    .VOICE_BITS(8),
    .NUM_VOICES(NV),
    .ACC_WIDTH(24)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [16:0] exp_q[$];   // pending output frame: {clipped, sample}
  int          frame_q[$]; // samples of the frame being collected
  bit          in_frame;
  logic [1:0]  m_prev;
  bit          exp_err;
  bit          exp_ovr;
  int          ready_mode;  // 0: ready=1, 1: ready=0, 2: random

  int          valid_cycles;
  int          err_pulses;
  int          ovr_pulses;
  int          seen_sample;
  int          seen_clip;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int floor_div_pow2(input int s, input int sh);
    int d;
    d = 1 << sh;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  // Reference: one call per rising edge, from the inputs as presented.
  task automatic model_edge();
    bit cap;
    bit done;
    int idx;
    int s;
    int sum;
    int sc;
    bit clip;
    cap    = (bus.i_pipeline_state == 2'd2) && (m_prev != 2'd2);
    m_prev = bus.i_pipeline_state;
    exp_err = 0;
    exp_ovr = 0;
    done    = 0;
    if (exp_q.size() != 0 && bus.i_sample_ready) void'(exp_q.pop_front());
    if (cap) begin
      idx = int'(bus.i_voice_index);
      s   = int'(bus.i_sample);
      if (!in_frame) begin
        if (idx == 0) begin
          frame_q  = {s};
          in_frame = 1;
        end
      end else if (idx == frame_q.size()) begin
        frame_q.push_back(s);
      end else if (idx == 0) begin
        exp_err = 1;
        frame_q = {s};
      end else begin
        exp_err  = 1;
        in_frame = 0;
        frame_q.delete();
      end
      if (in_frame && frame_q.size() == NV) begin
        done     = 1;
        in_frame = 0;
      end
    end
    if (done) begin
      sum = 0;
      foreach (frame_q[i]) sum += frame_q[i];
      frame_q.delete();
      sc   = floor_div_pow2(sum, int'(bus.i_gain_shift));
      clip = 0;
      if (sc > 32767) begin sc = 32767; clip = 1; end
      else if (sc < -32768) begin sc = -32768; clip = 1; end
      if (exp_q.size() != 0) begin
        exp_ovr = 1;
        exp_q.delete();
      end
      exp_q.push_back({clip, 16'(sc)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [16:0] e;
    case (ready_mode)
      0:       bus.i_sample_ready = 1'b1;
      1:       bus.i_sample_ready = 1'b0;
      default: bus.i_sample_ready = 1'($urandom_range(0, 1));
    endcase
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("frame_error", int'(bus.o_frame_error), int'(exp_err));
    check("overrun", int'(bus.o_overrun), int'(exp_ovr));
    check("valid", int'(bus.o_sample_valid), int'(exp_q.size() != 0));
    check("accum_state", int'(bus.o_dbg_accum), int'(in_frame));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("sample", int'(bus.o_sample), int'($signed(e[15:0])));
      check("clipped", int'(bus.o_clipped), int'(e[16]));
    end
    if (bus.o_sample_valid) begin
      valid_cycles++;
      seen_sample = int'(bus.o_sample);
      seen_clip   = int'(bus.o_clipped);
    end
    err_pulses += int'(bus.o_frame_error);
    ovr_pulses += int'(bus.o_overrun);
  endtask

  task automatic set_idle_phase();
    int p;
    p = $urandom_range(0, 2);
    bus.i_pipeline_state = (p == 2) ? 2'd3 : 2'(p);
  endtask

  // One voice: phase held at 2 for 'hold' edges, then one idle edge.
  task automatic voice(input int idx, input int s, input int hold);
    bus.i_pipeline_state = 2'd2;
    bus.i_voice_index    = 8'(idx);
    bus.i_sample         = 16'(s);
    repeat (hold) step();
    set_idle_phase();
    bus.i_voice_index = 8'($urandom_range(0, 255));
    bus.i_sample      = 16'($urandom);
    step();
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d);
    voice(0, a, 1);
    voice(1, b, 1);
    voice(2, c, 1);
    voice(3, d, 1);
  endtask

  task automatic clear_seen();
    valid_cycles = 0;
    err_pulses   = 0;
    ovr_pulses   = 0;
    seen_sample  = 0;
    seen_clip    = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_q.delete();
    in_frame = 0;
    m_prev   = 2'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx;
    int s;
    rst_n                = 1'b0;
    bus.i_pipeline_state = 2'd0;
    bus.i_voice_index    = '0;
    bus.i_sample         = '0;
    bus.i_gain_shift     = 4'd0;
    bus.i_sample_ready   = 1'b1;
    ready_mode           = 0;
    model_reset();
    clear_seen();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(bus.o_sample_valid), 0);
    check("rst_sample", int'(bus.o_sample), 0);
    check("rst_clipped", int'(bus.o_clipped), 0);
    check("rst_frame_error", int'(bus.o_frame_error), 0);
    check("rst_overrun", int'(bus.o_overrun), 0);
    check("rst_accum", int'(bus.o_dbg_accum), 0);
    rst_n = 1'b1;
    step();

    // basic sum
    clear_seen();
    frame4(100, 200, -50, 25);
    check("basic_sum", seen_sample, 275);
    check("basic_clip", seen_clip, 0);
    check("basic_pulses", valid_cycles, 1);

    // saturation both ways, then gain shift
    clear_seen();
    frame4(20000, 20000, 20000, 20000);
    check("sat_pos", seen_sample, 32767);
    check("sat_pos_clip", seen_clip, 1);
    frame4(-20000, -20000, -20000, -20000);
    check("sat_neg", seen_sample, -32768);
    check("sat_neg_clip", seen_clip, 1);
    bus.i_gain_shift = 4'd2;
    frame4(20000, 20000, 20000, 20000);
    check("shift2", seen_sample, 20000);
    check("shift2_clip", seen_clip, 0);
    bus.i_gain_shift = 4'd0;

    // out-of-sequence, then recovery
    clear_seen();
    voice(0, 1, 1); voice(1, 1, 1); voice(3, 1, 1);
    check("skip_err", err_pulses, 1);
    check("skip_no_out", valid_cycles, 0);
    frame4(1, 1, 1, 1);
    check("recover_sum", seen_sample, 4);
    clear_seen();
    voice(0, 10, 1); voice(1, 10, 1);
    frame4(10, 10, 10, 10);
    check("restart_err", err_pulses, 1);
    check("restart_sum", seen_sample, 40);

    // mid-stream start, phase held at 2 for two edges
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_seen();
    voice(2, 7, 2); voice(3, 7, 1);
    check("midstream_err", err_pulses, 0);
    check("midstream_out", valid_cycles, 0);
    voice(0, 3, 2); voice(1, 3, 2); voice(2, 3, 2); voice(3, 3, 2);
    check("midstream_sum", seen_sample, 12);

    // overrun with consumer stalled
    clear_seen();
    ready_mode = 1;
    frame4(1, 2, 3, 4);
    voice(0, 5, 1); voice(1, 5, 1); voice(2, 5, 1);
    check("held_sample", int'(bus.o_sample), 10);
    voice(3, 5, 1);
    check("overwrite_sample", seen_sample, 20);
    check("overrun_count", ovr_pulses, 1);
    // consumer ready exactly on the completion edge
    clear_seen();
    voice(0, 2, 1); voice(1, 2, 1); voice(2, 2, 1);
    ready_mode = 0;
    voice(3, 2, 1);
    check("xfer_no_overrun", ovr_pulses, 0);
    check("xfer_new_sample", seen_sample, 8);

    // async reset mid-frame with a pending output
    ready_mode = 1;
    frame4(9, 9, 9, 9);
    voice(0, 4, 1); voice(1, 4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_valid", int'(bus.o_sample_valid), 0);
    check("areset_sample", int'(bus.o_sample), 0);
    check("areset_clipped", int'(bus.o_clipped), 0);
    check("areset_accum", int'(bus.o_dbg_accum), 0);
    @(negedge clk);
    set_idle_phase();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    clear_seen();
    frame4(-3, 50, 60, -7);
    check("post_reset_sum", seen_sample, 100);

    // randomized streams
    for (int f = 0; f < 80; f++) begin
      ready_mode       = $urandom_range(0, 2);
      bus.i_gain_shift = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 2));
      for (int v = 0; v < NV; v++) begin
        idx = v;
        if ($urandom_range(0, 9) == 0) idx = $urandom_range(0, 5);
        if ($urandom_range(0, 3) == 0) s = int'($signed(16'($urandom)));
        else s = int'($urandom_range(0, 600)) - 300;
        if ($urandom_range(0, 7) == 0) bus.i_gain_shift = 4'($urandom_range(0, 15));
        voice(idx, s, $urandom_range(1, 2));
      end
    end
    ready_mode = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
